// File: rtl/alu_md.sv
// alu_md: combinational EX-stage ALU plus a sequential multiply/divide unit
// with HI/LO registers and a start/busy handshake of configurable latency.
module alu_md #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    input  logic [2:0]       md_op,
    input  logic             md_start,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    // ---------------- ALU ----------------
    logic [SHW-1:0] shamt;
    assign shamt = inA[SHW-1:0];
    assign Zero  = (inA == inB);

    // Combinational ALU result; unused encodings give 0
    always_comb begin
        ALUResult = '0;
        case (op)
            4'b0000: ALUResult = inA + inB;
            4'b0001: ALUResult = inA - inB;
            4'b0010: ALUResult = inA & inB;
            4'b0011: ALUResult = inA | inB;
            4'b0100: ALUResult = {inB[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            4'b0101: ALUResult = inA ^ inB;
            4'b0110: ALUResult = ~(inA | inB);
            4'b0111: ALUResult = {{(WIDTH-1){1'b0}}, ($signed(inA) < $signed(inB))};
            4'b1000: ALUResult = {{(WIDTH-1){1'b0}}, (inA < inB)};
            4'b1001: ALUResult = inB << shamt;
            4'b1010: ALUResult = inB >> shamt;
            4'b1011: ALUResult = WIDTH'($signed(inB) >>> shamt);
            default: ALUResult = '0;
        endcase
    end

    // ---------------- MD result datapath ----------------
    logic [2*WIDTH-1:0] ext_a, ext_b, prod_s, prod_u;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b, sdiv_b, udiv_b;
    logic [WIDTH-1:0]   uq, ur, sq_mag, sr_mag, sq, sr;

    // Signed divide is done on magnitudes so MIN / -1 naturally yields
    // quotient MIN (magnitude wraps) and remainder 0 with no special case.
    // Zero divisors are replaced by 1 only to keep the dividers defined;
    // the result is never written back in that case.
    always_comb begin
        ext_a  = {{WIDTH{inA[WIDTH-1]}}, inA};
        ext_b  = {{WIDTH{inB[WIDTH-1]}}, inB};
        prod_s = ext_a * ext_b;
        prod_u = {{WIDTH{1'b0}}, inA} * {{WIDTH{1'b0}}, inB};
        a_neg  = inA[WIDTH-1];
        b_neg  = inB[WIDTH-1];
        abs_a  = a_neg ? -inA : inA;
        abs_b  = b_neg ? -inB : inB;
        sdiv_b = (abs_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
        udiv_b = (inB == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : inB;
        uq     = inA / udiv_b;
        ur     = inA % udiv_b;
        sq_mag = abs_a / sdiv_b;
        sr_mag = abs_a % sdiv_b;
        sq     = (a_neg ^ b_neg) ? -sq_mag : sq_mag;
        sr     = a_neg ? -sr_mag : sr_mag;
    end

    // ---------------- MD control ----------------
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, wr_q, wr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] pend_q, pend_d;

    // Next-state: count down while busy and commit on the last cycle,
    // otherwise accept a new request
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        busy_d = busy_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                if (wr_q) {hi_d, lo_d} = pend_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (md_start) begin
            case (md_op)
                MD_MULT, MD_MULTU: begin
                    busy_d = 1'b1;
                    wr_d   = 1'b1;
                    cnt_d  = CW'(MULT_CYCLES - 1);
                    pend_d = (md_op == MD_MULT) ? prod_s : prod_u;
                end
                MD_DIV, MD_DIVU: begin
                    busy_d = 1'b1;
                    wr_d   = (inB != '0);
                    cnt_d  = CW'(DIV_CYCLES - 1);
                    pend_d = (md_op == MD_DIV) ? {sr, sq} : {ur, uq};
                end
                MD_MTHI: hi_d = inA;
                MD_MTLO: lo_d = inA;
                default: ;
            endcase
        end
    end

    // State registers with synchronous active-low reset (aborts any op)
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            wr_q   <= 1'b0;
            cnt_q  <= '0;
            pend_q <= '0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md at WIDTH=32, 5/10 cycle latency.
module tb_alu_md;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic [31:0] inA, inB, ALUResult, hi, lo;
    logic        Zero, busy, md_start;
    logic [2:0]  md_op;

    int total = 0;
    int bad   = 0;

    alu_md #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .op(op), .inA(inA), .inB(inB),
        .ALUResult(ALUResult), .Zero(Zero), .md_op(md_op),
        .md_start(md_start), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input string tag, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        op = o; inA = a; inB = b;
        #1;
        chk(tag, ALUResult, exp);
    endtask

    // issue one md request for a single edge
    task automatic md(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b);
        md_op = mop; inA = a; inB = b; md_start = 1'b1;
        step();
        md_start = 1'b0; md_op = 3'd0;
    endtask

    // count remaining busy cycles, bounded
    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 50) begin
            n++;
            step();
        end
    endtask

    int n;

    initial begin
        reset = 1'b0; op = 4'd0; inA = '0; inB = '0; md_op = 3'd0; md_start = 1'b0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        reset = 1'b1;

        // ALU sweep
        alu("addu",  4'b0000, 32'hFFFFFFFF, 32'h1, 32'h0);
        alu("subu",  4'b0001, 32'h0, 32'h1, 32'hFFFFFFFF);
        alu("and",   4'b0010, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000);
        alu("or",    4'b0011, 32'hF0000000, 32'h0000000F, 32'hF000000F);
        alu("lui",   4'b0100, 32'h0, 32'h00001234, 32'h12340000);
        alu("xor",   4'b0101, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F);
        alu("nor",   4'b0110, 32'h0, 32'h0, 32'hFFFFFFFF);
        alu("slt",   4'b0111, 32'hFFFFFFFF, 32'h1, 32'h1);
        alu("sltu",  4'b1000, 32'hFFFFFFFF, 32'h1, 32'h0);
        alu("sll33", 4'b1001, 32'd33, 32'h1, 32'h2);
        alu("srl",   4'b1010, 32'd4, 32'h80000000, 32'h08000000);
        alu("sra",   4'b1011, 32'd4, 32'h80000000, 32'hF8000000);
        alu("op15",  4'b1111, 32'h5, 32'h3, 32'h0);
        inA = 32'h1234; inB = 32'h1234; #1; chk("zero_eq", Zero, 1);
        inB = 32'h1235; #1; chk("zero_ne", Zero, 0);

        // MULT -2*3; operands change after acceptance
        md(3'd1, 32'hFFFFFFFE, 32'd3);
        inA = 32'd100; inB = 32'd100;
        busy_len(n);
        chk("mult_busy", n, 5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);

        // MULTU with ignored MULT and MTLO while busy
        md(3'd2, 32'hFFFFFFFE, 32'd3);
        md(3'd1, 32'd7, 32'd9);
        md(3'd6, 32'h77, 32'h0);
        busy_len(n);
        chk("multu_busy", n, 3);
        chk("multu_hi", hi, 32'h2);
        chk("multu_lo", lo, 32'hFFFFFFFA);

        // start in the first cycle after busy falls
        md(3'd5, 32'h55, 32'h0);
        chk("mthi_hi", hi, 32'h55);
        chk("mthi_busy", busy, 0);

        // DIV -7/2
        md(3'd3, 32'hFFFFFFF9, 32'd2);
        busy_len(n);
        chk("div_busy", n, 10);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        // DIV MIN / -1
        md(3'd3, 32'h80000000, 32'hFFFFFFFF);
        busy_len(n);
        chk("divov_lo", lo, 32'h80000000);
        chk("divov_hi", hi, 32'h0);

        // DIVU 100/7
        md(3'd4, 32'd100, 32'd7);
        busy_len(n);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        // DIVU by zero keeps hi/lo
        md(3'd5, 32'h11, 32'h0);
        md(3'd6, 32'h22, 32'h0);
        md(3'd4, 32'd7, 32'd0);
        busy_len(n);
        chk("div0_busy", n, 10);
        chk("div0_hi", hi, 32'h11);
        chk("div0_lo", lo, 32'h22);

        // reset in cycle 3 of a DIV
        md(3'd3, 32'd100, 32'd7);
        step();
        reset = 1'b0;
        step();
        chk("rmid_busy", busy, 0);
        chk("rmid_hi", hi, 0);
        chk("rmid_lo", lo, 0);
        reset = 1'b1;
        repeat (15) step();
        chk("rlate_busy", busy, 0);
        chk("rlate_hi", hi, 0);
        chk("rlate_lo", lo, 0);

        // start held during reset is not accepted
        reset = 1'b0;
        md(3'd5, 32'h99, 32'h0);
        chk("rstart_hi", hi, 0);
        md_op = 3'd1; inA = 32'd3; inB = 32'd3; md_start = 1'b1;
        step();
        md_start = 1'b0; md_op = 3'd0;
        reset = 1'b1;
        step();
        chk("rstart_busy", busy, 0);
        repeat (8) step();
        chk("rstart_lo", lo, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
